// File: rtl/viterbi_pkg.sv
// Shared constants and types for the Viterbi add-compare-select / path-metric unit.
//
// Contents:
//   NUM_STATES, BM_W, PM_W, INIT_PEN  - trellis size and metric widths
//   NB, ST_W                          - butterfly count and state-index width
//   state_e                           - frame FSM states
//   init_metric()                     - frame-start path metric of a state
package viterbi_pkg;

    localparam int unsigned NUM_STATES = 64;
    localparam int unsigned BM_W       = 2;
    localparam int unsigned PM_W       = 8;
    localparam int unsigned INIT_PEN   = 32;

    localparam int unsigned NB   = NUM_STATES / 2;
    localparam int unsigned ST_W = $clog2(NUM_STATES);

    typedef enum logic [0:0] {
        IDLE,
        RUN
    } state_e;

    // State 0 is the known encoder start state; every other state starts penalised.
    function automatic logic [PM_W-1:0] init_metric(input int s);
        return (s == 0) ? '0 : PM_W'(INIT_PEN);
    endfunction

endpackage

// File: rtl/acs_butterfly.sv
// One radix-2 trellis butterfly: two add-compare-select operations sharing the
// predecessor pair (2i, 2i+1).
//
// Ports:
//   pm_even, pm_odd - path metrics of predecessors 2i and 2i+1
//   bm0, bm1        - branch metrics of the butterfly
//   new_lo, dec_lo  - metric / decision for new state i
//   new_hi, dec_hi  - metric / decision for new state i+NB
// Decision 1 selects the odd predecessor; ties keep the even one.
module acs_butterfly
    import viterbi_pkg::*;
(
    input  logic [PM_W-1:0] pm_even,
    input  logic [PM_W-1:0] pm_odd,
    input  logic [BM_W-1:0] bm0,
    input  logic [BM_W-1:0] bm1,
    output logic [PM_W-1:0] new_lo,
    output logic [PM_W-1:0] new_hi,
    output logic            dec_lo,
    output logic            dec_hi
);

    localparam int unsigned SW = PM_W + 1;

    logic [SW-1:0] sum_a, sum_b, sum_c, sum_d;

    always_comb begin
        // One extra bit so the compare is exact before truncation.
        sum_a  = SW'(pm_even) + SW'(bm0);
        sum_b  = SW'(pm_odd)  + SW'(bm1);
        sum_c  = SW'(pm_even) + SW'(bm1);
        sum_d  = SW'(pm_odd)  + SW'(bm0);
        dec_lo = (sum_b < sum_a);
        dec_hi = (sum_d < sum_c);
        // Surviving metric always fits PM_W bits because the spread stays bounded.
        new_lo = dec_lo ? sum_b[PM_W-1:0] : sum_a[PM_W-1:0];
        new_hi = dec_hi ? sum_d[PM_W-1:0] : sum_c[PM_W-1:0];
    end

endmodule

// File: rtl/viterbi_acs_pmu.sv
// Add-compare-select and path-metric unit for a hard-decision rate-1/2 Viterbi
// decoder. Consumes one beat of butterfly branch metrics per symbol, updates the
// path-metric bank and emits one survivor-decision word per symbol.
//
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   in_valid/in_ready            - branch-metric beat handshake
//   in_bm                        - butterfly i: bm0 at [2i*BM_W +: BM_W], bm1 at [(2i+1)*BM_W +: BM_W]
//   in_sof/in_eof                - frame delimiters
//   dec_valid/dec_ready          - decision word handshake
//   dec_bits, dec_sof, dec_eof   - registered decision word and frame flags
//   sof_err                      - pulse when a beat without sof is dropped in IDLE
//   best_state                   - index of the smallest new metric (optional)
//
// Optional feature: define VITERBI_ACS_BEST_STATE_EN to add best_state.
module viterbi_acs_pmu
    import viterbi_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_STATES*BM_W-1:0] in_bm,
    input  logic                       in_sof,
    input  logic                       in_eof,
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output logic [NUM_STATES-1:0]      dec_bits,
    output logic                       dec_sof,
    output logic                       dec_eof,
    output logic                       sof_err
`ifdef VITERBI_ACS_BEST_STATE_EN
    ,
    output logic [ST_W-1:0]            best_state
`endif
);

    state_e                state_q, state_d;
    logic [PM_W-1:0]       pm_q [NUM_STATES];
    logic [PM_W-1:0]       pm_d [NUM_STATES];
    logic [PM_W-1:0]       src_pm [NUM_STATES];
    logic [PM_W-1:0]       acs_pm [NUM_STATES];
    logic [PM_W-1:0]       norm_pm [NUM_STATES];
    logic [NUM_STATES-1:0] acs_dec;
    logic                  all_hi;

    logic                  dec_valid_q, dec_valid_d;
    logic [NUM_STATES-1:0] dec_bits_q, dec_bits_d;
    logic                  dec_sof_q, dec_sof_d;
    logic                  dec_eof_q, dec_eof_d;
    logic                  sof_err_q, sof_err_d;

    logic                  accept, process, drop;

    assign in_ready = !dec_valid_q || dec_ready;
    assign accept   = in_valid && in_ready;
    assign process  = accept && ((state_q == RUN) || in_sof);
    assign drop     = accept && (state_q == IDLE) && !in_sof;

    // A sof beat starts from the init metrics, whatever the bank holds.
    always_comb begin
        for (int s = 0; s < NUM_STATES; s++) begin
            src_pm[s] = in_sof ? init_metric(s) : pm_q[s];
        end
    end

    for (genvar i = 0; i < NB; i++) begin : g_bfly
        acs_butterfly u_bfly (
            .pm_even (src_pm[2*i]),
            .pm_odd  (src_pm[2*i+1]),
            .bm0     (in_bm[2*i*BM_W +: BM_W]),
            .bm1     (in_bm[(2*i+1)*BM_W +: BM_W]),
            .new_lo  (acs_pm[i]),
            .new_hi  (acs_pm[i+NB]),
            .dec_lo  (acs_dec[i]),
            .dec_hi  (acs_dec[i+NB])
        );
    end

    // Renormalise by dropping the MSB once every metric has it set; the
    // spread is below half range, so relative order is preserved.
    always_comb begin
        all_hi = 1'b1;
        for (int s = 0; s < NUM_STATES; s++) begin
            all_hi = all_hi & acs_pm[s][PM_W-1];
        end
        for (int s = 0; s < NUM_STATES; s++) begin
            norm_pm[s] = acs_pm[s];
            if (all_hi) begin
                norm_pm[s][PM_W-1] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pm_d        = pm_q;
        dec_valid_d = dec_valid_q;
        dec_bits_d  = dec_bits_q;
        dec_sof_d   = dec_sof_q;
        dec_eof_d   = dec_eof_q;
        sof_err_d   = drop;

        if (process) begin
            state_d     = in_eof ? IDLE : RUN;
            pm_d        = norm_pm;
            dec_valid_d = 1'b1;
            dec_bits_d  = acs_dec;
            dec_sof_d   = in_sof;
            dec_eof_d   = in_eof;
        end else if (dec_ready) begin
            dec_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dec_valid_q <= 1'b0;
            dec_bits_q  <= '0;
            dec_sof_q   <= 1'b0;
            dec_eof_q   <= 1'b0;
            sof_err_q   <= 1'b0;
            for (int s = 0; s < NUM_STATES; s++) begin
                pm_q[s] <= init_metric(s);
            end
        end else begin
            state_q     <= state_d;
            dec_valid_q <= dec_valid_d;
            dec_bits_q  <= dec_bits_d;
            dec_sof_q   <= dec_sof_d;
            dec_eof_q   <= dec_eof_d;
            sof_err_q   <= sof_err_d;
            pm_q        <= pm_d;
        end
    end

    assign dec_valid = dec_valid_q;
    assign dec_bits  = dec_bits_q;
    assign dec_sof   = dec_sof_q;
    assign dec_eof   = dec_eof_q;
    assign sof_err   = sof_err_q;

`ifdef VITERBI_ACS_BEST_STATE_EN
    logic [ST_W-1:0] best_state_q, best_state_d, best_idx;
    logic [PM_W-1:0] best_val;

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        best_idx = '0;
        best_val = norm_pm[0];
        for (int s = 1; s < NUM_STATES; s++) begin
            if (norm_pm[s] < best_val) begin
                best_val = norm_pm[s];
                best_idx = ST_W'(s);
            end
        end
        best_state_d = process ? best_idx : best_state_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            best_state_q <= '0;
        end else begin
            best_state_q <= best_state_d;
        end
    end

    assign best_state = best_state_q;
`endif

endmodule

// File: doc/viterbi_acs_pmu.md
Name: viterbi_acs_pmu

Overview:
- Add-compare-select and path-metric unit for the hard-decision, rate-1/2 Viterbi decoder.
- Sits directly downstream of the branch-metric stage. Consumes one set of butterfly branch metrics per received symbol.
- Updates the path-metric bank for all states and emits one survivor-decision word per symbol to the traceback stage.
- Handles frame start/end, metric initialisation and overflow-free renormalisation.

Parameters:
- NUM_STATES, 64, trellis states (power of 2, >=4); butterflies NB = NUM_STATES/2.
- BM_W, 2, branch-metric width (hard-decision metric range 0..2).
- PM_W, 8, path-metric width; must be >=6.
- INIT_PEN, 32, initial metric for every state except state 0 at frame start; must be < 2^(PM_W-1).

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset.
- in_valid, input, 1: branch-metric beat valid.
- in_ready, output, 1: unit accepts beat.
- in_bm, input, NUM_STATES*BM_W: butterfly i has bm0 at [2i*BM_W +: BM_W] and bm1 at [(2i+1)*BM_W +: BM_W].
- in_sof, input, 1: first symbol of frame.
- in_eof, input, 1: last symbol of frame.
- dec_valid, output, 1: decision word valid.
- dec_ready, input, 1: traceback accepts decision word.
- dec_bits, output, NUM_STATES: survivor decision per new state.
- dec_sof, output, 1: registered copy of in_sof.
- dec_eof, output, 1: registered copy of in_eof.
- sof_err, output, 1: one-cycle pulse when a beat without sof is dropped in IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values:
  - dec_valid=0, dec_bits=0, dec_sof=0, dec_eof=0, sof_err=0.
  - FSM=IDLE.
  - pm[0]=0; pm[s]=INIT_PEN for s!=0.
- Handshake:
  - in_ready = !dec_valid | dec_ready.
  - A beat is accepted when in_valid & in_ready.
  - dec_* stays stable while dec_valid & !dec_ready.
  - Latency is 1 cycle: an accepted beat sets dec_valid on the next edge.
  - Full throughput of 1 symbol/cycle when dec_ready=1.
- FSM:
  - IDLE: a beat with sof is processed and moves to RUN; a beat without sof is consumed, dropped and pulses sof_err.
  - RUN: every accepted beat is processed.
  - An accepted beat with eof returns to IDLE after processing.
  - sof & eof in the same beat is a one-symbol frame; FSM stays or returns to IDLE.
  - sof in RUN restarts the frame; FSM stays RUN.
- Source metrics: on a processed sof beat, the ACS uses the reset-init values (pm[0]=0, others INIT_PEN), not the register bank.
- ACS for butterfly i (predecessors 2i and 2i+1):
  - a = pm[2i]+bm0, b = pm[2i+1]+bm1 -> new[i] = min(a,b); dec_bits[i] = (b<a).
  - c = pm[2i]+bm1, d = pm[2i+1]+bm0 -> new[i+NB] = min(c,d); dec_bits[i+NB] = (d<c).
  - Ties select the even predecessor (decision 0).
  - Sums are computed at PM_W+1 bits.
- Renormalisation: if bit PM_W-1 is set in every new metric, clear that bit in all new metrics before registering. The metric spread stays below 2^(PM_W-1), so no wrap occurs.
- Update rule: the path-metric bank updates only on processed beats. Dropped beats, stalls and idle cycles hold it.
- rst mid-frame: restores reset values at once; any pending dec word is lost.

Optional Feature:
- Macro: VITERBI_ACS_BEST_STATE_EN.
- When defined: adds output best_state [log2(NUM_STATES)-1:0], registered with dec_bits.
  - It holds the index of the minimum post-renormalisation new metric; the lowest index wins ties.
  - Reset value is 0.
  - The compare tree is a combinational pipeline input, so latency is unchanged.
- When undefined: the port and the compare tree are absent. Traceback starts from state 0.

Decomposition:
- Package viterbi_pkg holds:
  - NUM_STATES, BM_W, PM_W and INIT_PEN defaults.
  - Derived constants NB and ST_W.
  - FSM state typedef {IDLE, RUN}.
- Sub-module acs_butterfly: two ACS ops for one butterfly. It takes pm_even, pm_odd, bm0 and bm1, and returns two new metrics and two decision bits.
- The top module instantiates NB butterflies via generate and holds the bank, renormalisation, FSM and output register.

Test Plan:
- Reset then idle: dec_valid=0, in_ready=1, sof_err=0.
- sof beat, all bm0=0, bm1=2 -> next cycle:
  - dec_valid=1, dec_sof=1.
  - dec_bits[63:33]=all 1, dec_bits[32:0]=0.
  - Next metrics: pm[0]=0, pm[32]=2, pm[1..31]=32, pm[33..63]=32.
- Backpressure: dec_ready=0 with two beats offered -> in_ready=0 after the first; dec_bits stable. Release -> second beat accepted, no loss or duplication.
- Beat with in_sof=0 in IDLE -> sof_err=1 for one cycle, no dec_valid, metrics unchanged.
- 1000 random-bm symbols between sof and eof, random dec_ready:
  - dec_bits match a golden model including renormalisation.
  - No metric exceeds 255.
  - dec_eof set on the last word; FSM returns to IDLE.
- sof asserted mid-frame -> decisions restart from init metrics; sof and eof in the same beat -> single word with dec_sof=dec_eof=1.
